pattern_detector_n: RTL
=======================

# pattern_detector_n

Parametrised Mealy serial pattern detector: watches a one-bit serial stream and flags, in the same cycle as the final bit, each occurrence of an N-bit programmable pattern. It generalises the fixed 1010 sequence recogniser with run-time pattern load, an overlapping or non-overlapping match mode, a sample-enable qualifier and a saturating match counter. It sits between a serial input front end and any logic that consumes match events or statistics.

## Interface
- N, 4: pattern length in bits; legal range N >= 2.
- CW, 8: width of the match counter.
- RESET_PATTERN, 4'b1010 (N bits): pattern value after reset.
- clk  input  1  clock; all state updates on the posedge.
- reset  input  1  synchronous, active-high reset; sampled on the posedge of clk.
- x  input  1  serial data bit.
- valid  input  1  when high, x is a sample this cycle; when low, x is ignored and all state holds.
- load  input  1  when high, latch `pattern` and restart detection.
- pattern  input  N  new pattern; the first-received bit is the MSB.
- overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- y  output  1  Mealy match flag, combinational, valid in the cycle of the final pattern bit.
- match_count  output  CW  number of matches since reset or last load; saturates at all ones.

## Operation
- Registered state:
  - pat_q[N-1:0]: active pattern.
  - hist[N-2:0]: last N-1 accepted bits, with the newest bit at the LSB.
  - fill: number of valid history bits, saturating at N-1.
  - cnt[CW-1:0]: match counter.
- Match condition: y = valid & !load & !reset & (fill == N-1) & ({hist, x} == pat_q).
- Posedge update priority, highest first:
  - reset: pat_q = RESET_PATTERN; hist = 0; fill = 0; cnt = 0.
  - load: pat_q = pattern; hist = 0; fill = 0; cnt = 0. Any sample presented this cycle is discarded.
  - valid with y = 1 and overlap = 0: hist = 0; fill = 0; cnt increments.
  - valid otherwise: hist = {hist[N-3:0], x}, or hist = x when N = 2; fill = min(fill+1, N-1). If y = 1, cnt increments.
  - valid low: all state holds.
- cnt saturates: an increment at all ones leaves cnt at all ones.
- overlap is sampled each cycle. A change takes effect on the next match.
- Reset values: y = 0, because fill = 0; match_count = 0.

## Timing
- Latency from the final pattern bit to y is zero cycles (combinational, same cycle). match_count reflects the match after the following posedge.
- Detection needs N accepted samples after reset, after load, or (in non-overlap mode) after a match.
- Simultaneous load and valid: load wins, y = 0, and the sample is lost.
- Simultaneous reset and load: reset wins, and pat_q = RESET_PATTERN.
- Reset mid-sequence: partial history is discarded, so no match can complete using bits accepted before the reset.
- valid low for any number of cycles: the partial match is preserved, and y = 0 during those cycles.
- The pattern is compared in full. There is no don't-care support.

## Test plan
- Overlapping match:
  - Setup: N = 4, after reset, overlap = 1, valid = 1.
  - Stimulus: x = 1,0,1,0,1,0.
  - Required: y = 1 on the 4th and 6th samples only; match_count = 2.
- Non-overlapping match:
  - Setup: same stream, overlap = 0.
  - Required: y = 1 on the 4th sample only; match_count = 1.
  - Follow-on: then 1,0 -> y = 1 on that final 0 (the 4th bit after restart); match_count = 2.
- Valid gaps:
  - Stimulus: 1,0 with valid = 1; then 3 cycles valid = 0 with x = 1; then 1,0 with valid = 1.
  - Required: y = 1 on the last sample; no y during the gap.
- Pattern load:
  - Stimulus: load pattern = 4'b1101 mid-stream with valid = 1 that cycle, then send 1,1,0,1.
  - Required: y = 1 on the final 1; match_count = 1 (it was cleared by load).
  - Check: the sample presented in the load cycle is not counted.
- Counter saturation:
  - Setup: CW = 2, overlap = 1.
  - Stimulus: 1,0,1,0,1,0,1,0,1,0.
  - Required: 4 matches; match_count stays at 3 after the 3rd match.
- Reset mid-sequence:
  - Stimulus: 1,0,1, then assert reset for one cycle, then 0.
  - Required: y = 0 throughout; match_count = 0. A subsequent 1,0,1,0 gives y = 1 on the final 0.

Source files
------------

// File: rtl/pattern_detector_n.sv
// Mealy serial pattern detector: flags each occurrence of a run-time loadable
// N-bit pattern in a qualified one-bit stream, with overlap control and a saturating match count.
module pattern_detector_n #(
  parameter int             N             = 4,
  parameter int             CW            = 8,
  parameter logic [N-1:0]   RESET_PATTERN = 4'b1010
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x,
  input  logic          valid,
  input  logic          load,
  input  logic [N-1:0]  pattern,
  input  logic          overlap,
  output logic          y,
  output logic [CW-1:0] match_count
);

  localparam int FW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]  r_pat;
  logic [N-2:0]  r_hist;
  logic [FW-1:0] r_fill;
  logic [CW-1:0] r_cnt;

  logic [N-1:0]  w_window;
  logic          w_full;
  logic          w_match;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [FW-1:0] fill_inc(input logic [FW-1:0] f);
    return (f == FW'(N - 1)) ? f : f + 1'b1;
  endfunction

  // The window is the stored history plus the bit arriving this cycle; its
  // low N-1 bits are also the next history, which works for N = 2 as well.
  assign w_window = {r_hist, x};
  assign w_full   = (r_fill == FW'(N - 1));

  always_comb begin
    w_match = valid & ~load & ~reset & w_full & (w_window == r_pat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= RESET_PATTERN;
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else if (load) begin
      r_pat  <= pattern;
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
    end else if (valid) begin
      if (w_match && !overlap) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[N-2:0];
        r_fill <= fill_inc(r_fill);
      end
      if (w_match) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  assign y           = w_match;
  assign match_count = r_cnt;

endmodule
